// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state codes, opcodes and datapath control encodings for multi_cycle_ctrl
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory wait counter with sticky timeout flag
module mem_wait_timer #(
  parameter int WAIT_CNT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cnt_en_i,
  input  logic clr_i,
  output logic err_o
);

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // err rises on the same edge the counter reaches all-ones
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) err_d = 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control FSM; CTRL_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_CNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       ZeroExt_o,
  output logic [2:0] ALU_op_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] state_o,
  output logic       err_o,
  output logic       illegal_o
);

  state_e state_q, state_d;
  logic   pc_write, pc_write_cond, mem_write, ir_write, reg_write;
  logic   wait_en;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_B;
    ZeroExt_o     = 1'b0;
    ALU_op_o      = ALU_ADD;
    PCSource_o    = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB_o = SRCB_IMM_SH;
        case (instr_op_i)
          OP_RTYPE:       state_d = S_EXEC_R;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_EXEC_I;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:        state_d = S_TRAP;
`else
          default:        state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        MemtoReg_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        RegDst_o  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        if (instr_op_i == OP_ORI) begin
          ALU_op_o  = ALU_ORI;
          ZeroExt_o = 1'b1;
        end else begin
          ALU_op_o  = ALU_ADDI;
        end
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o      = ALU_SUB;
        pc_write_cond = 1'b1;
        PCSource_o    = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        PCSource_o = PCSRC_JUMP;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        pc_write   = 1'b1;
        PCSource_o = PCSRC_TRAP;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are gated by reset so nothing commits while rst_i is low
  assign PCWrite_o     = pc_write      & rst_i;
  assign PCWriteCond_o = pc_write_cond & rst_i;
  assign MemWrite_o    = mem_write     & rst_i;
  assign IRWrite_o     = ir_write      & rst_i;
  assign RegWrite_o    = reg_write     & rst_i;
  assign state_o       = state_q;

  assign wait_en = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                   && !mem_ready_i;

  mem_wait_timer #(
    .WAIT_CNT_W(WAIT_CNT_W)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cnt_en_i (wait_en),
    .clr_i    (state_d != state_q),
    .err_o    (err_o)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 illegal_q <= 1'b0;
    else if (state_q == S_TRAP) illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

endmodule
